// File: rtl/reg_rename_file.sv
// Architectural register file x0..x31 with per-register ROB rename tags and commit bypass.
// Reads are combinational (zero latency); reserve/commit/flush take effect at the next clk_in edge.
// No backpressure: rdy_in low freezes state (flush and reset still act), reads stay live.
//
// Ports:
//   clk_in, rst_in (sync, active-high), rdy_in, flush_in
//   rs1/rs2_request -> rsN_value, rsN_rename (zero-extended tag), rsN_if_rename
//   reserve_enable/rd/reorder : rename a destination to a new ROB producer
//   commit_enable/des/value/reorder : write back a committed result
module reg_rename_file #(
    parameter int REG_NUM   = 32,
    parameter int ROB_IDX_W = 4,
    parameter int DATA_W    = 32
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 flush_in,

    input  logic [4:0]           rs1_request,
    input  logic [4:0]           rs2_request,
    output logic [DATA_W-1:0]    rs1_value,
    output logic [DATA_W-1:0]    rs2_value,
    output logic [DATA_W-1:0]    rs1_rename,
    output logic [DATA_W-1:0]    rs2_rename,
    output logic                 rs1_if_rename,
    output logic                 rs2_if_rename,

    input  logic                 reserve_enable,
    input  logic [4:0]           reserve_rd,
    input  logic [ROB_IDX_W-1:0] reserve_reorder,

    input  logic                 commit_enable,
    input  logic [4:0]           commit_des,
    input  logic [DATA_W-1:0]    commit_value,
    input  logic [ROB_IDX_W-1:0] commit_reorder
);

    typedef struct packed {
        logic [DATA_W-1:0] value;
        logic [DATA_W-1:0] rename;
        logic              if_rename;
    } rd_result_t;

    logic [DATA_W-1:0]    value_q [REG_NUM];
    logic [ROB_IDX_W-1:0] tag_q   [REG_NUM];
    logic [REG_NUM-1:0]   busy_q;

    rd_result_t rd1, rd2;

    // One read port. The bypass only fires when the committing entry is the
    // register's current producer; a stale-tag commit leaves the register pending.
    function automatic rd_result_t read_port(
        input logic [4:0]           idx,
        input logic [DATA_W-1:0]    val,
        input logic [ROB_IDX_W-1:0] tag,
        input logic                 busy
    );
        rd_result_t r;
        r = '0;
        if (idx == 5'd0) begin
            r = '0;
        end else if (commit_enable && commit_des == idx && busy && tag == commit_reorder) begin
            r.value = commit_value;
        end else if (busy) begin
            r.rename    = {{(DATA_W-ROB_IDX_W){1'b0}}, tag};
            r.if_rename = 1'b1;
        end else begin
            r.value = val;
        end
        return r;
    endfunction

    always_comb begin
        rd1 = read_port(rs1_request, value_q[rs1_request], tag_q[rs1_request], busy_q[rs1_request]);
        rd2 = read_port(rs2_request, value_q[rs2_request], tag_q[rs2_request], busy_q[rs2_request]);
    end

    assign rs1_value     = rd1.value;
    assign rs1_rename    = rd1.rename;
    assign rs1_if_rename = rd1.if_rename;
    assign rs2_value     = rd2.value;
    assign rs2_rename    = rd2.rename;
    assign rs2_if_rename = rd2.if_rename;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < REG_NUM; i++) begin
                value_q[i] <= '0;
                tag_q[i]   <= '0;
            end
            busy_q <= '0;
        end else if (flush_in) begin
            // JAL/JALR commit alongside the flush, so the value write must survive it.
            if (commit_enable && commit_des != 5'd0)
                value_q[commit_des] <= commit_value;
            for (int i = 0; i < REG_NUM; i++)
                tag_q[i] <= '0;
            busy_q <= '0;
        end else if (rdy_in) begin
            if (commit_enable && commit_des != 5'd0) begin
                value_q[commit_des] <= commit_value;
                if (tag_q[commit_des] == commit_reorder)
                    busy_q[commit_des] <= 1'b0;
            end
            // Placed after the commit so a same-register reserve overrides the busy clear.
            if (reserve_enable && reserve_rd != 5'd0) begin
                tag_q[reserve_rd]  <= reserve_reorder;
                busy_q[reserve_rd] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_reg_rename_file.sv
module tb_reg_rename_file;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, flush_in;
    logic [4:0]  rs1_request, rs2_request;
    logic [31:0] rs1_value, rs2_value, rs1_rename, rs2_rename;
    logic        rs1_if_rename, rs2_if_rename;
    logic        reserve_enable;
    logic [4:0]  reserve_rd;
    logic [3:0]  reserve_reorder;
    logic        commit_enable;
    logic [4:0]  commit_des;
    logic [31:0] commit_value;
    logic [3:0]  commit_reorder;

    int total = 0;
    int bad   = 0;

    always #5 clk_in = ~clk_in;

    reg_rename_file #(.REG_NUM(32), .ROB_IDX_W(4), .DATA_W(32)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .rs1_request(rs1_request), .rs2_request(rs2_request),
        .rs1_value(rs1_value), .rs2_value(rs2_value),
        .rs1_rename(rs1_rename), .rs2_rename(rs2_rename),
        .rs1_if_rename(rs1_if_rename), .rs2_if_rename(rs2_if_rename),
        .reserve_enable(reserve_enable), .reserve_rd(reserve_rd), .reserve_reorder(reserve_reorder),
        .commit_enable(commit_enable), .commit_des(commit_des),
        .commit_value(commit_value), .commit_reorder(commit_reorder)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive both read ports with idx and check value/rename/if_rename on each.
    task automatic look(input string tag, input logic [4:0] idx,
                        input logic [31:0] v, input logic [31:0] r, input logic f);
        rs1_request = idx;
        rs2_request = idx;
        #1;
        chk({tag, ".v1"}, rs1_value, v);
        chk({tag, ".r1"}, rs1_rename, r);
        chk({tag, ".f1"}, {31'd0, rs1_if_rename}, {31'd0, f});
        chk({tag, ".v2"}, rs2_value, v);
        chk({tag, ".r2"}, rs2_rename, r);
        chk({tag, ".f2"}, {31'd0, rs2_if_rename}, {31'd0, f});
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        reserve_enable = 0; reserve_rd = 0; reserve_reorder = 0;
        commit_enable = 0; commit_des = 0; commit_value = 0; commit_reorder = 0;
        flush_in = 0;
    endtask

    task automatic reserve(input logic [4:0] rd, input logic [3:0] t);
        reserve_enable = 1; reserve_rd = rd; reserve_reorder = t;
    endtask

    task automatic commit(input logic [4:0] d, input logic [31:0] v, input logic [3:0] t);
        commit_enable = 1; commit_des = d; commit_value = v; commit_reorder = t;
    endtask

    initial begin
        idle();
        rdy_in = 1; rst_in = 1; rs1_request = 0; rs2_request = 0;
        tick();
        tick();
        rst_in = 0;

        // Reset state
        look("rst_x5", 5'd5, 32'h0, 32'h0, 1'b0);
        look("rst_x0", 5'd0, 32'h0, 32'h0, 1'b0);

        // Rename then commit with bypass
        reserve(5'd5, 4'd3); tick(); idle();
        look("x5_busy", 5'd5, 32'h0, 32'd3, 1'b1);
        commit(5'd5, 32'hDEADBEEF, 4'd3);
        look("x5_bypass", 5'd5, 32'hDEADBEEF, 32'h0, 1'b0);
        tick(); idle();
        look("x5_done", 5'd5, 32'hDEADBEEF, 32'h0, 1'b0);

        // Stale-tag commit: no bypass, stays pending on newer tag
        reserve(5'd7, 4'd2); tick();
        reserve(5'd7, 4'd6); tick(); idle();
        commit(5'd7, 32'h11, 4'd2);
        look("x7_nobyp", 5'd7, 32'h0, 32'd6, 1'b1);
        tick(); idle();
        look("x7_stale", 5'd7, 32'h0, 32'd6, 1'b1);

        // Same-cycle commit and reserve on one register
        reserve(5'd9, 4'd1); tick(); idle();
        commit(5'd9, 32'h55, 4'd1); reserve(5'd9, 4'd4); tick(); idle();
        look("x9_resv_wins", 5'd9, 32'h0, 32'd4, 1'b1);

        // Flush with simultaneous commit; reserve during flush ignored
        commit(5'd2, 32'hAB, 4'd9); tick(); idle();
        reserve(5'd1, 4'd0); tick();
        reserve(5'd2, 4'd1); tick(); idle();
        look("x2_busy", 5'd2, 32'h0, 32'd1, 1'b1);
        flush_in = 1; commit(5'd1, 32'h1000, 4'd0); reserve(5'd3, 4'd7);
        tick(); idle();
        look("fl_x1", 5'd1, 32'h1000, 32'h0, 1'b0);
        look("fl_x2", 5'd2, 32'hAB, 32'h0, 1'b0);
        look("fl_x3", 5'd3, 32'h0, 32'h0, 1'b0);
        look("fl_x7", 5'd7, 32'h11, 32'h0, 1'b0);
        look("fl_x9", 5'd9, 32'h55, 32'h0, 1'b0);

        // rdy_in low freezes state; reads stay live
        rdy_in = 0; commit(5'd3, 32'h77, 4'd0); reserve(5'd4, 4'd5);
        look("hold_live", 5'd5, 32'hDEADBEEF, 32'h0, 1'b0);
        tick(); tick(); idle(); rdy_in = 1;
        look("hold_x3", 5'd3, 32'h0, 32'h0, 1'b0);
        look("hold_x4", 5'd4, 32'h0, 32'h0, 1'b0);

        // x0 writes and reserves discarded
        commit(5'd0, 32'h99, 4'd0); reserve(5'd0, 4'd3);
        look("x0_same", 5'd0, 32'h0, 32'h0, 1'b0);
        tick(); idle();
        look("x0_after", 5'd0, 32'h0, 32'h0, 1'b0);

        // Mid-run reset, even with rdy_in low
        reserve(5'd6, 4'd8); tick(); idle();
        look("x6_busy", 5'd6, 32'h0, 32'd8, 1'b1);
        rst_in = 1; rdy_in = 0; tick(); rst_in = 0; rdy_in = 1;
        look("rst2_x5", 5'd5, 32'h0, 32'h0, 1'b0);
        look("rst2_x1", 5'd1, 32'h0, 32'h0, 1'b0);
        look("rst2_x6", 5'd6, 32'h0, 32'h0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
